// File: rtl/uart_byte_tx_if.sv
// rtl/uart_byte_tx_if.sv - byte handshake and serial line bundle for uart_byte_tx
//
// Signals:
//   txData   [7:0] byte to send, sampled on an accepted txStart
//   txStart        single-cycle request strobe
//   txStatus       1 = frame in progress, 0 = idle and able to accept
//   txd            serial line, idle high
//   txDone         one-cycle pulse when a frame completes
// Modports:
//   master  upstream pixel buffer read side (drives txData/txStart)
//   slave   the transmitter (drives txStatus/txd/txDone)

interface uart_byte_tx_if;
  logic [7:0] txData;
  logic       txStart;
  logic       txStatus;
  logic       txd;
  logic       txDone;

  modport master (
    output txData,
    output txStart,
    input  txStatus,
    input  txd,
    input  txDone
  );

  modport slave (
    input  txData,
    input  txStart,
    output txStatus,
    output txd,
    output txDone
  );
endinterface

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - UART byte serialiser for the camera pixel read path
//
// Ports:
//   clk      read-side clock
//   reset_n  asynchronous active-low reset
//   tx       uart_byte_tx_if.slave: txData/txStart in, txStatus/txd/txDone out
// Frame: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop
// bits, each held for DIVISOR clocks. All outputs are registered.

module uart_byte_tx #(
  parameter logic [15:0] DIVISOR   = 16'd434,
  parameter logic [1:0]  PARITY    = 2'd0,
  parameter int          STOP_BITS = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_byte_tx_if.slave  tx
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY_BIT,
    STOP
  } txState_e;

  // PARITY = 3 falls back to no parity; any STOP_BITS other than 2 means one.
  localparam logic       PAR_EN    = (PARITY == 2'd1) || (PARITY == 2'd2);
  localparam logic       PAR_ODD   = (PARITY == 2'd1);
  localparam logic [2:0] STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;
  localparam logic [15:0] BAUD_LAST = DIVISOR - 16'd1;

  txState_e    state, stateNext;
  logic [15:0] baudCnt, baudNext;
  logic [2:0]  bitIdx, bitNext;
  logic [7:0]  shiftReg, shiftNext;
  logic        parityAcc, parityNext;
  logic        txdReg, txdNext;
  logic        statusReg, statusNext;
  logic        doneReg, doneNext;
  logic        baudWrap;

  assign baudWrap = (baudCnt == BAUD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      baudCnt   <= 16'd0;
      bitIdx    <= 3'd0;
      shiftReg  <= 8'd0;
      parityAcc <= 1'b0;
      txdReg    <= 1'b1;
      statusReg <= 1'b0;
      doneReg   <= 1'b0;
    end else begin
      state     <= stateNext;
      baudCnt   <= baudNext;
      bitIdx    <= bitNext;
      shiftReg  <= shiftNext;
      parityAcc <= parityNext;
      txdReg    <= txdNext;
      statusReg <= statusNext;
      doneReg   <= doneNext;
    end
  end

  // Outputs are computed for the state being entered so that the registered
  // txd/txStatus/txDone line up with the state register.
  always_comb begin
    stateNext  = state;
    baudNext   = baudCnt;
    bitNext    = bitIdx;
    shiftNext  = shiftReg;
    parityNext = parityAcc;
    txdNext    = txdReg;
    statusNext = statusReg;
    doneNext   = 1'b0;

    if (state != IDLE) begin
      baudNext = baudWrap ? 16'd0 : baudCnt + 16'd1;
    end

    case (state)
      IDLE: begin
        txdNext    = 1'b1;
        statusNext = 1'b0;
        if (tx.txStart) begin
          stateNext  = START;
          shiftNext  = tx.txData;
          baudNext   = 16'd0;
          bitNext    = 3'd0;
          parityNext = 1'b0;
          txdNext    = 1'b0;
          statusNext = 1'b1;
        end
      end

      START: begin
        if (baudWrap) begin
          stateNext = DATA;
          bitNext   = 3'd0;
          txdNext   = shiftReg[0];
        end
      end

      DATA: begin
        if (baudWrap) begin
          parityNext = parityAcc ^ shiftReg[0];
          shiftNext  = {1'b0, shiftReg[7:1]};
          if (bitIdx == 3'd7) begin
            if (PAR_EN) begin
              stateNext = PARITY_BIT;
              // Accumulator already holds bits 0..6; fold in bit 7 here.
              txdNext   = parityAcc ^ shiftReg[0] ^ PAR_ODD;
            end else begin
              stateNext = STOP;
              bitNext   = 3'd0;
              txdNext   = 1'b1;
            end
          end else begin
            bitNext = bitIdx + 3'd1;
            txdNext = shiftReg[1];
          end
        end
      end

      PARITY_BIT: begin
        if (baudWrap) begin
          stateNext = STOP;
          bitNext   = 3'd0;
          txdNext   = 1'b1;
        end
      end

      STOP: begin
        if (baudWrap) begin
          if (bitIdx == STOP_LAST) begin
            stateNext  = IDLE;
            statusNext = 1'b0;
            doneNext   = 1'b1;
            txdNext    = 1'b1;
          end else begin
            bitNext = bitIdx + 3'd1;
          end
        end
      end

      default: begin
        stateNext  = IDLE;
        txdNext    = 1'b1;
        statusNext = 1'b0;
      end
    endcase
  end

  assign tx.txd      = txdReg;
  assign tx.txStatus = statusReg;
  assign tx.txDone   = doneReg;

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb/tb_uart_byte_tx.sv - scoreboard bench for uart_byte_tx over several configurations

module tb_uart_byte_tx;

  localparam int NCFG = 5;
  localparam int NDIR = 7;
  localparam int NRND = 12;

  typedef struct {
    logic [7:0] data;
    int         acc;
  } item_t;

  function automatic int cfgDiv(int g);
    return (g == 4) ? 2 : 4;
  endfunction

  function automatic int cfgPar(int g);
    case (g)
      1: return 2;
      2: return 1;
      4: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int cfgStop(int g);
    case (g)
      3: return 2;
      4: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int frameBits(int par, int stop);
    return 9 + (((par == 1) || (par == 2)) ? 1 : 0) + ((stop == 2) ? 2 : 1);
  endfunction

  // Line level of bit slot idx within a frame carrying d.
  function automatic int expBit(logic [7:0] d, int idx, int par, int stop);
    int x;
    if (idx == 0) return 0;
    if (idx <= 8) return int'(d[idx-1]);
    if (((par == 1) || (par == 2)) && (idx == 9)) begin
      x = 0;
      for (int i = 0; i < 8; i++) x = x ^ int'(d[i]);
      return (par == 1) ? (1 - x) : x;
    end
    return (stop < 0) ? 0 : 1;
  endfunction

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic go = 1'b0;
  logic rtStart = 1'b0;
  int checks = 0;
  int failures = 0;

  logic [NCFG-1:0] txdAll, statusAll, doneAll, finAll;

  logic [7:0] dirData [NDIR] = '{8'hA5, 8'h07, 8'hFF, 8'h5A, 8'h00, 8'h81, 8'h3C};
  int         dirKind [NDIR] = '{0, 0, 0, 0, 1, 0, 0};
  int         dirGap  [NDIR] = '{1, 3, 2, 1, 0, 2, 0};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int inst, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t got=%0d exp=%0d", nm, inst, $time, got, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : inst
    localparam int DIV  = cfgDiv(g);
    localparam int PAR  = cfgPar(g);
    localparam int STOP = cfgStop(g);
    localparam int NB   = frameBits(PAR, STOP);

    uart_byte_tx_if bus ();

    logic       startG = 1'b0;
    logic [7:0] dataG = 8'h00;
    logic       finG = 1'b0;
    int         eG = 0;
    int         freeG = 0;
    int         lastAcc = 0;
    item_t      q[$];
    item_t      it;
    item_t      cur;
    int         act = 0;
    int         startE = 0;
    int         idx = 0;

    assign bus.txStart = startG | rtStart;
    assign bus.txData  = dataG;
    assign txdAll[g]    = bus.txd;
    assign statusAll[g] = bus.txStatus;
    assign doneAll[g]   = bus.txDone;
    assign finAll[g]    = finG;

    uart_byte_tx #(
      .DIVISOR  (16'(DIV)),
      .PARITY   (2'(PAR)),
      .STOP_BITS(STOP)
    ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .tx     (bus.slave)
    );

    // Acceptance model: a strobe is taken only once the previous frame's
    // 1 + DIV*NB cycles have elapsed.
    always @(posedge clk) begin
      eG = eG + 1;
      if (!reset_n) begin
        freeG = 0;
      end else if (bus.txStart && (eG >= freeG)) begin
        it.data = bus.txData;
        it.acc  = eG;
        q.push_back(it);
        lastAcc = eG;
        freeG   = eG + DIV * NB + 1;
      end
    end

    always @(negedge clk) begin
      if (!reset_n) begin
        act = 0;
        q.delete();
      end else begin
        if (act == 0) begin
          if (bus.txd === 1'b0) begin
            chk("start_pending", g, int'(q.size() > 0), 1);
            if (q.size() > 0) begin
              cur    = q.pop_front();
              act    = 1;
              startE = cur.acc;
              chk("start_latency", g, eG, cur.acc);
            end
          end else begin
            chk("idle_status", g, int'(bus.txStatus), 0);
            chk("idle_done", g, int'(bus.txDone), 0);
            if ((q.size() > 0) && (eG >= q[0].acc)) begin
              chk("start_missing", g, int'(bus.txd), 0);
              void'(q.pop_front());
            end
          end
        end
        if (act != 0) begin
          idx = eG - startE;
          if (idx < DIV * NB) begin
            chk("txd_level", g, int'(bus.txd), expBit(cur.data, idx / DIV, PAR, STOP));
            chk("busy", g, int'(bus.txStatus), 1);
            chk("done_early", g, int'(bus.txDone), 0);
          end else begin
            chk("done_pulse", g, int'(bus.txDone), 1);
            chk("done_status", g, int'(bus.txStatus), 0);
            chk("done_txd", g, int'(bus.txd), 1);
            act = 0;
          end
        end
      end
    end

    // kind 0: strobe gap cycles after the line is free (gap 0 = back-to-back)
    // kind 1: strobe 10 cycles into the running frame (must be ignored)
    initial begin : stim
      int target;
      int kind;
      int gap;
      int prevKind;
      logic [7:0] data;
      prevKind = 1;
      wait (go);
      @(posedge clk);
      #1;
      for (int i = 0; i < NDIR + NRND; i++) begin
        if (i < NDIR) begin
          data = dirData[i];
          kind = dirKind[i];
          gap  = dirGap[i];
        end else begin
          data = 8'($urandom);
          kind = ((prevKind == 0) && ($urandom_range(0, 3) == 0)) ? 1 : 0;
          gap  = $urandom_range(0, 3);
        end
        target = (kind == 1) ? lastAcc + 10 : freeG + gap;
        if (target <= eG) target = eG + 1;
        while (eG < target - 1) begin
          @(posedge clk);
          #1;
        end
        startG = 1'b1;
        dataG  = data;
        @(posedge clk);
        #1;
        startG = 1'b0;
        dataG  = 8'($urandom);
        prevKind = kind;
      end
      while (eG < freeG + 2) begin
        @(posedge clk);
        #1;
      end
      finG = 1'b1;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_txd", -1, int'(txdAll), (1 << NCFG) - 1);
    chk("rst_status", -1, int'(statusAll), 0);
    chk("rst_done", -1, int'(doneAll), 0);
    reset_n = 1'b1;
    go = 1'b1;
    for (int c = 0; (c < 20000) && (finAll != '1); c++) @(posedge clk);
    chk("stim_finished", -1, int'(finAll), (1 << NCFG) - 1);

    // Reset in the middle of a start bit must release the line at once.
    @(posedge clk);
    #1 rtStart = 1'b1;
    @(posedge clk);
    #1 rtStart = 1'b0;
    @(posedge clk);
    #1;
    chk("rt_start_bit", -1, int'(txdAll), 0);
    chk("rt_busy", -1, int'(statusAll), (1 << NCFG) - 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rt_async_txd", -1, int'(txdAll), (1 << NCFG) - 1);
    chk("rt_async_status", -1, int'(statusAll), 0);
    chk("rt_async_done", -1, int'(doneAll), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_txd", -1, int'(txdAll), (1 << NCFG) - 1);
    chk("post_rst_status", -1, int'(statusAll), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
